// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and small operation-decode helpers.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// W-bit adder/subtractor shared by the multiply and divide iterations.
// o_carry is the raw carry-out: for subtraction, 1 means no borrow (a >= b).
module muldiv_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_carry
);

  logic [W-1:0] w_b;
  logic [W:0]   w_full;

  assign w_b     = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_sub};
  assign o_sum   = w_full[W-1:0];
  assign o_carry = w_full[W];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO. Works on operand magnitudes,
// one shift-add or restoring-divide step per RUN cycle, signs applied in FIXUP.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t r_state;
  state_t w_state_next;

  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_a;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_acc_hi;   // product high half or partial remainder
  logic [WIDTH-1:0] r_acc_lo;   // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0] r_in1;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_is_div;
  logic             r_res_neg;
  logic             r_rem_neg;
  logic             r_div0;
  logic             r_done;

  // Operand capture at start
  logic             w_signed;
  logic             w_in1_neg;
  logic             w_in2_neg;
  logic [WIDTH-1:0] w_in1_mag;
  logic [WIDTH-1:0] w_in2_mag;

  assign w_signed  = op_is_signed(op);
  assign w_in1_neg = w_signed & in1[WIDTH-1];
  assign w_in2_neg = w_signed & in2[WIDTH-1];
  assign w_in1_mag = w_in1_neg ? -in1 : in1;
  assign w_in2_mag = w_in2_neg ? -in2 : in2;

  // Shared datapath adder: add for multiply, trial subtract for divide
  logic [WIDTH:0] w_add_a;
  logic [WIDTH:0] w_add_b;
  logic [WIDTH:0] w_sum;
  logic           w_carry;

  assign w_add_a = r_is_div ? {r_acc_hi, r_acc_lo[WIDTH-1]} : {1'b0, r_acc_hi};
  assign w_add_b = {1'b0, r_a};

  muldiv_addsub #(
    .W(WIDTH + 1)
  ) u_addsub (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_sub  (r_is_div),
    .o_sum  (w_sum),
    .o_carry(w_carry)
  );

  // One iteration step
  logic [WIDTH:0]   w_mul_acc;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH-1:0] w_iter_lo;

  assign w_mul_acc = r_acc_lo[0] ? w_sum : {1'b0, r_acc_hi};

  always_comb begin
    w_iter_hi = r_acc_hi;
    w_iter_lo = r_acc_lo;
    if (r_is_div) begin
      // Carry-out set means the trial subtraction did not borrow
      w_iter_hi = w_carry ? w_sum[WIDTH-1:0] : w_add_a[WIDTH-1:0];
      w_iter_lo = {r_acc_lo[WIDTH-2:0], w_carry};
    end else begin
      w_iter_hi = w_mul_acc[WIDTH:1];
      w_iter_lo = {w_mul_acc[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fixup and final result selection
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_res_neg ? -w_prod : w_prod;
  assign w_quot_fix = r_res_neg ? -r_acc_lo : r_acc_lo;
  assign w_rem_fix  = r_rem_neg ? -r_acc_hi : r_acc_hi;

  always_comb begin
    w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod_fix[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_res_hi = r_in1;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_rem_fix;
        w_res_lo = w_quot_fix;
      end
    end
  end

  // FSM next-state and busy
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_count == CNT_W'(WIDTH - 1)) w_state_next = FIXUP;
      end
      FIXUP: begin
        busy         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_a       <= '0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_in1     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_res_neg <= 1'b0;
      r_rem_neg <= 1'b0;
      r_div0    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == FIXUP);
      case (r_state)
        IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_count   <= '0;
            r_is_div  <= op_is_div(op);
            r_a       <= w_in2_mag;
            r_acc_hi  <= '0;
            r_acc_lo  <= w_in1_mag;
            r_in1     <= in1;
            r_res_neg <= w_in1_neg ^ w_in2_neg;
            r_rem_neg <= w_in1_neg;
            r_div0    <= op_is_div(op) && (in2 == '0);
          end
        end
        RUN: begin
          r_acc_hi <= w_iter_hi;
          r_acc_lo <= w_iter_lo;
          r_count  <= r_count + CNT_W'(1);
        end
        FIXUP: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_count <= '0;
        end
        default: r_count <= '0;
      endcase
    end
  end

  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, signed/unsigned results,
// divide-by-zero, MTHI/MTLO interaction and mid-operation reset.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_fail;

  muldiv_unit #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .in1  (in1),
    .in2  (in2),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one start cycle; returns positioned in cycle k+1
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    tick();
    start = 1'b0;
  endtask

  // Watches a bounded window starting at cycle k+1
  task automatic observe(output int busy_cnt, output int done_at, output int done_cnt,
                         output logic [31:0] h, output logic [31:0] l);
    busy_cnt = 0;
    done_at  = 0;
    done_cnt = 0;
    h        = '0;
    l        = '0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = i;
          h = hi;
          l = lo;
        end
      end
      tick();
    end
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    int bc, da, dc;
    logic [31:0] h, l;
    launch(o, a, b);
    observe(bc, da, dc, h, l);
    $display("%s: op=%0d in1=0x%08h in2=0x%08h -> hi=0x%08h lo=0x%08h busy=%0d done_at=%0d",
             tag, o, a, b, h, l, bc, da);
    check_eq({tag, "_busy_cycles"}, 32'(bc), 32'd33);
    check_eq({tag, "_done_at"}, 32'(da), 32'd34);
    check_eq({tag, "_done_count"}, 32'(dc), 32'd1);
    check_eq({tag, "_hi"}, h, exp_hi);
    check_eq({tag, "_lo"}, l, exp_lo);
  endtask

  initial begin
    int bc, da, dc;
    logic [31:0] h, l;
    logic [31:0] hi_run;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    in1      = '0;
    in2      = '0;
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    wdata    = '0;
    tick();
    tick();
    reset = 1'b0;
    $display("reset: busy=%0b done=%0b hi=0x%08h lo=0x%08h", busy, done, hi, lo);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_hi", hi, 32'h0);
    check_eq("reset_lo", lo, 32'h0);

    run_check("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_check("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_check("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_check("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_check("divu_zero", 2'd3, 32'h0000_0064, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_check("divu_plain", 2'd3, 32'd1000, 32'd7, 32'd6, 32'd142);

    // MTLO alone in IDLE
    lo_we = 1'b1;
    wdata = 32'hCAFE_F00D;
    tick();
    lo_we = 1'b0;
    $display("mtlo: hi=0x%08h lo=0x%08h", hi, lo);
    check_eq("mtlo_lo", lo, 32'hCAFE_F00D);
    check_eq("mtlo_hi_kept", hi, 32'd6);

    // MTHI together with a MULTU start; a second start at cycle 5 must be ignored
    start = 1'b1;
    op    = 2'd1;
    in1   = 32'd2;
    in2   = 32'd3;
    hi_we = 1'b1;
    wdata = 32'h0000_1234;
    tick();
    start  = 1'b0;
    hi_we  = 1'b0;
    da     = 0;
    dc     = 0;
    h      = '0;
    l      = '0;
    hi_run = '0;
    for (int i = 1; i <= 45; i++) begin
      if (i == 2) hi_run = hi;
      start = (i == 5);
      in1   = 32'd5;
      in2   = 32'd5;
      if (done) begin
        dc++;
        if (da == 0) begin
          da = i;
          h = hi;
          l = lo;
        end
      end
      tick();
    end
    start = 1'b0;
    $display("mthi_start: hi_run=0x%08h hi=0x%08h lo=0x%08h done_at=%0d dones=%0d",
             hi_run, h, l, da, dc);
    check_eq("mthi_hi_during_run", hi_run, 32'h0000_1234);
    check_eq("mthi_done_at", 32'(da), 32'd34);
    check_eq("mthi_done_count", 32'(dc), 32'd1);
    check_eq("mthi_hi", h, 32'h0);
    check_eq("mthi_lo", l, 32'd6);

    // Reset in cycle 10 of a DIVU aborts it
    launch(2'd3, 32'd100, 32'd7);
    for (int i = 1; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("abort: busy=%0b done=%0b hi=0x%08h lo=0x%08h", busy, done, hi, lo);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_hi", hi, 32'h0);
    check_eq("abort_lo", lo, 32'h0);
    observe(bc, da, dc, h, l);
    check_eq("abort_no_done", 32'(dc), 32'd0);
    check_eq("abort_idle_busy", 32'(bc), 32'd0);

    run_check("after_abort", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU over a fixed number of cycles and owns the architectural HI/LO registers.
- It also services MTHI/MTLO writes.
- Sits beside the EX-stage ALU. The hazard unit stalls on busy for any MFHI/MFLO or new mul/div that issues while an operation is in flight.

Parameters:
WIDTH, 32, operand/HI/LO width
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch operation; sampled only in IDLE
op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
in1  input  WIDTH  rs operand (multiplicand/dividend)
in2  input  WIDTH  rt operand (multiplier/divisor)
hi_we  input  1  MTHI write enable
lo_we  input  1  MTLO write enable
wdata  input  WIDTH  MTHI/MTLO data
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse, first cycle new HI/LO is visible
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; hi=0; lo=0; busy=0; done=0; counter=0. Reset mid-operation aborts and discards the partial result.
- FSM states and transitions:
  - IDLE -> RUN when start.
  - RUN -> RUN while count<WIDTH-1; RUN -> FIXUP when count==WIDTH-1.
  - FIXUP -> IDLE unconditionally.
- Start at edge k:
  - Operands are latched as magnitudes: abs() for signed ops, raw for unsigned ops.
  - Sign flags are latched: result sign = sign(in1) xor sign(in2); remainder sign = sign(in1).
- Cycle timing:
  - RUN occupies cycles k+1..k+WIDTH (one iteration per cycle).
  - FIXUP is cycle k+WIDTH+1.
  - IDLE at k+WIDTH+2, where hi/lo hold the result and done=1 for that single cycle.
  - busy=1 for cycles k+1..k+WIDTH+1. Fixed latency, data-independent.
- Multiply iteration (unsigned shift-add on magnitudes): if multiplier LSB then acc_hi += multiplicand; shift {carry,acc_hi,acc_lo} right 1.
- Multiply FIXUP: 2*WIDTH-bit product, negated (two's complement over 2*WIDTH) if the result sign is set; hi=upper, lo=lower.
- Divide iteration (restoring): rem={rem,quot MSB}; trial=rem-divisor; if trial non-negative then rem=trial, quotient bit=1.
- Divide FIXUP: lo=quotient (negated if result sign set); hi=remainder (negated if remainder sign set).
- Divide by zero (in2==0, any div op): same latency; FIXUP writes lo=all ones, hi=in1 as originally latched (unmodified).
- DIV 0x80000000 / 0xFFFFFFFF: magnitude arithmetic gives lo=0x80000000, hi=0. No trap.
- start while busy: ignored; no queueing.
- hi_we/lo_we:
  - In IDLE, write at the edge.
  - While busy, ignored; the hazard unit guarantees this does not occur.
  - In FIXUP, ignored (result wins).
- start and hi_we/lo_we in the same IDLE cycle: both take effect; the write is visible until the result overwrites it at FIXUP.
- hi/lo keep their prior values throughout RUN. Partial results are never visible.

Decomposition:
- Package muldiv_pkg holds the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the FSM state enum (IDLE, RUN, FIXUP).
- One sub-module, muldiv_addsub: WIDTH+1-bit adder/subtractor shared by the multiply and divide iterations. Selected by a sub input; outputs sum and carry/borrow.
- FSM, counter, operand/sign registers and HI/LO are in muldiv_unit.

Test Plan:
- Reset, then MULTU in1=0xFFFFFFFF in2=0xFFFFFFFF:
  - busy high for exactly 33 cycles.
  - done pulses at cycle 34 after start with hi=0xFFFFFFFE, lo=0x00000001.
- MULT in1=0xFFFFFFFD (-3) in2=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV in1=0xFFFFFFF9 (-7) in2=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV in1=0x80000000 in2=0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU in1=0x64 in2=0: after the same 34-cycle latency, lo=0xFFFFFFFF, hi=0x64.
- MTHI wdata=0x1234 with start (MULTU 2*3) in the same cycle: hi=0x1234 during RUN, then hi=0, lo=6 at done. Second start at cycle 5 is ignored (only one done).
- Reset asserted at cycle 10 of a DIVU: next cycle busy=0, hi=lo=0, no done pulse. A new start then completes normally.
